// File: rtl/bcd_adder_serial.sv
// Digit-serial BCD adder/subtractor: one shared digit slice processes
// DIGITS packed BCD digits least-significant first, pulsing done at the end.
module bcd_adder_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   sum_q, sum_d;
    logic                  cout_q, cout_d;
    logic                  err_q, err_d;
    logic                  carry_q, carry_d;
    logic [IW-1:0]         idx_q, idx_d;

    logic [4*DIGITS-1:0]   x_q, y_q;
    logic                  sub_q;
    logic                  load;

    logic [3:0]            a_dig, y_dig, b_dig;
    logic [4:0]            slice;

    function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] v,
                                            input logic [IW-1:0] i);
        logic [3:0] r;
        r = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (i == IW'(d)) r = v[4*d +: 4];
        end
        return r;
    endfunction

    function automatic logic any_invalid(input logic [4*DIGITS-1:0] v);
        logic r;
        r = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    // Returns {carry_out, digit}; the +6 correction skips the six non-BCD codes.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic       c);
        logic [4:0] t;
        logic [4:0] tc;
        t  = {1'b0, a} + {1'b0, b} + {4'd0, c};
        tc = t + 5'd6;
        if (t > 5'd9) return {1'b1, tc[3:0]};
        return {1'b0, t[3:0]};
    endfunction

    assign a_dig = digit_at(x_q, idx_q);
    assign y_dig = digit_at(y_q, idx_q);
    assign b_dig = sub_q ? (4'd9 - y_dig) : y_dig;
    assign slice = bcd_digit_add(a_dig, b_dig, carry_q);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        load    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    carry_d = sub ? 1'b1 : cin;
                    err_d   = any_invalid(x) | any_invalid(y);
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int d = 0; d < DIGITS; d++) begin
                    if (idx_q == IW'(d)) sum_d[4*d +: 4] = slice[3:0];
                end
                carry_d = slice[4];
                if (idx_q == IW'(DIGITS - 1)) begin
                    cout_d  = slice[4];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    // Operand registers are pure data and only change on an accepted start.
    always_ff @(posedge clk) begin
        if (load) begin
            x_q   <= x;
            y_q   <= y;
            sub_q <= sub;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_bcd_adder_serial.sv
// Directed-vector bench for bcd_adder_serial (DIGITS=4) with hand-computed results.
module tb_bcd_adder_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_adder_serial #(.DIGITS(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .cin  (cin),
        .x    (x),
        .y    (y),
        .sum  (sum),
        .cout (cout),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 20);
    endtask

    task automatic run_op(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                          input logic s, input logic c, input logic chk_sum,
                          input logic [15:0] es, input logic ec, input logic ee);
        int cyc;
        @(negedge clk);
        x = xv; y = yv; sub = s; cin = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq({tag, "_busy"}, busy, 1'b1);
        check_eq({tag, "_err"}, err, ee);
        wait_done(cyc);
        check_eq({tag, "_lat"}, cyc, 4);
        if (chk_sum) begin
            check_eq({tag, "_sum"}, sum, es);
            check_eq({tag, "_cout"}, cout, ec);
        end
        @(posedge clk);
        #1;
        check_eq({tag, "_donefall"}, done, 1'b0);
    endtask

    initial begin
        int cyc;
        int seen;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; x = '0; y = '0;
        #12;
        check_eq("rst_sum", sum, 16'h0);
        check_eq("rst_ctl", {cout, busy, done, err}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        run_op("add",     16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0);
        run_op("ripple",  16'h9999, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("addcin",  16'h9999, 16'h9999, 1'b0, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b0);
        run_op("subpos",  16'h5000, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h3766, 1'b1, 1'b0);
        run_op("subneg",  16'h1234, 16'h5000, 1'b1, 1'b1, 1'b1, 16'h6234, 1'b0, 1'b0);
        run_op("invalid", 16'h00A0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        run_op("errclr",  16'h0005, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h0009, 1'b0, 1'b0);

        // A start pulse in the middle of RUN must not disturb the result.
        @(negedge clk);
        x = 16'h1111; y = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        x = 16'h8888; y = 16'h7777; sub = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
        check_eq("midrun_lat", cyc, 2);
        check_eq("midrun_sum", sum, 16'h3333);
        check_eq("midrun_cout", cout, 1'b0);

        // start held through DONE relaunches without an IDLE cycle.
        @(negedge clk);
        x = 16'h0001; y = 16'h0002; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        x = 16'h0456; y = 16'h9544;
        wait_done(cyc);
        check_eq("b2b1_lat", cyc, 4);
        check_eq("b2b1_sum", sum, 16'h0003);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("b2b_busy", busy, 1'b1);
        check_eq("b2b_done", done, 1'b0);
        wait_done(cyc);
        check_eq("b2b2_lat", cyc, 4);
        check_eq("b2b2_sum", sum, 16'h0000);
        check_eq("b2b2_cout", cout, 1'b1);

        // Asynchronous reset while digit 2 is being processed.
        @(negedge clk);
        x = 16'h00B1; y = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("rstmid_err", err, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("rstmid_sum", sum, 16'h0);
        check_eq("rstmid_ctl", {cout, busy, done, err}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check_eq("rstmid_nodone", seen, 0);
        run_op("fresh", 16'h4321, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h5432, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_adder_serial.md
# bcd_adder_serial

Digit-serial multi-digit BCD adder/subtractor and the parametrised successor of the team's single-digit BCD full adder. Operands of `DIGITS` packed BCD digits are latched on a start pulse and processed one digit per clock, least-significant digit first, through one shared digit-adder slice. A `done` pulse marks the result. It sits between operand registers and display or result logic wherever wide decimal arithmetic is needed without a full ripple chain of digit adders.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand. Legal range is ≥1. Index counter width is clog2(DIGITS), minimum 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a new operation. Sampled only in IDLE or DONE.
- `sub` input 1: 0 = add, 1 = subtract (X − Y). Latched with `start`.
- `cin` input 1: carry-in for add mode. Latched with `start`. Ignored when `sub`=1.
- `x` input 4*DIGITS: packed BCD operand X. Digit i is `x[4i+3:4i]`.
- `y` input 4*DIGITS: packed BCD operand Y, same packing.
- `sum` output 4*DIGITS: packed BCD result.
- `cout` output 1: final decimal carry. In subtract mode, 1 = no borrow.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse when the result is valid.
- `err` output 1: at least one latched input nibble was greater than 9.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE, `sum`=0, `cout`=0, `busy`=0, `done`=0, `err`=0, internal carry=0 and index=0.
- IDLE or DONE with `start`=1:
  - Latch `x`, `y` and `sub`.
  - Initial carry = `sub` ? 1 : `cin`.
  - `err` = OR over all latched nibbles of (nibble > 9).
  - index = 0. Go to RUN.
- DONE with `start`=0: go to IDLE. `done` falls. `sum`, `cout` and `err` are held.
- RUN, each cycle, with a = X digit[index] and b = `sub` ? (9 − Y digit[index]) mod 16 : Y digit[index]:
  - t = a + b + carry, computed at 5-bit width.
  - If t > 9: digit = (t + 6)[3:0] and carry' = 1.
  - Otherwise: digit = t[3:0] and carry' = 0.
  - Write the digit into `sum` digit[index]. Store carry'.
  - If index = DIGITS−1: `cout` = carry', go to DONE. Otherwise index + 1.
- Invalid (>9) nibbles pass through the same rule without any special handling. The result is then unspecified, but the FSM is unaffected.
- Subtract result:
  - `cout`=1: `sum` = X − Y.
  - `cout`=0: `sum` = 10^DIGITS − (Y − X), i.e. the ten's complement.
- `start` during RUN is ignored. No queuing.
- Reset asserted mid-operation aborts immediately to reset values. No `done` is produced.

## Timing
- `start` high at edge E0 means the operands are latched at E0. `busy`=1 from E0 until E0+DIGITS.
- Digit i is written at edge E0+1+i.
- `done`=1 and `cout` are valid for exactly one cycle after edge E0+DIGITS. Latency is DIGITS cycles.
- `sum` changes digit by digit during RUN. It is only meaningful while `done`=1 or afterwards until the next accepted `start`.
- `start` held high in DONE launches the next operation back-to-back, giving a throughput of one result per DIGITS+1 cycles.
- `err` is valid from the cycle after E0.

## Test plan
- Add, DIGITS=4: x=0x1234, y=0x5678, cin=0. Expect `done` 4 cycles after `start`, `sum`=0x6912, `cout`=0, `err`=0.
- Full carry ripple: x=0x9999, y=0x0001, cin=0 gives `sum`=0x0000, `cout`=1. Then x=y=0x9999, cin=1 gives `sum`=0x9999, `cout`=1.
- Subtract: x=0x5000, y=0x1234, sub=1 gives `sum`=0x3766, `cout`=1. Then x=0x1234, y=0x5000 gives `sum`=0x6234, `cout`=0. Check that `cin`=1 is ignored in both.
- Invalid digit: x=0x00A0, y=0x0000. Expect `err`=1 the cycle after `start` and `done` still after 4 cycles. The next valid operation clears `err` to 0.
- Control:
  - Pulse `start` again mid-RUN with different operands. The first result must be unaffected.
  - Hold `start` high through DONE. The second operation must start with no IDLE cycle.
- Reset: assert `rst` asynchronously at digit 2 of an operation. All outputs must go to 0 immediately with no `done`. A fresh `start` then completes normally.
